// File: rtl/gray_pkg.sv
// Shared Gray-code definitions used by the counter and by the downstream
// Gray-to-binary stage, so both sides agree on one encoding.
package gray_pkg;

  localparam int unsigned GRAY_W     = 4;
  // Conversion functions operate on this width; callers zero-extend / truncate.
  localparam int unsigned GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Prefix XOR from the MSB down; leading zero bits leave the result unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2gray_comb.sv
// WIDTH-parameterised combinational binary-to-Gray converter.
module bin2gray_comb
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray_c
);

  assign o_gray_c = WIDTH'(bin2gray(GRAY_MAX_W'(i_bin)));

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with load, wrap/saturate and a wrap pulse.
// Define GRAY_CNT_BIN_OUT_EN to expose the registered binary count on 'bin'.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             at_end
`ifdef GRAY_CNT_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] bin
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_at_end;

  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_wrap_nxt;
  logic             w_at_end_nxt;

  // Next binary count: load beats enable; range ends either wrap or hold.
  always_comb begin
    w_bin_nxt  = r_bin;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_bin_nxt = load_val;
    end else if (en) begin
      if (up) begin
        if (r_bin == CNT_MAX) begin
          if (WRAP) begin
            w_bin_nxt  = CNT_ZERO;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_bin_nxt = r_bin + WIDTH'(1);
        end
      end else begin
        if (r_bin == CNT_ZERO) begin
          if (WRAP) begin
            w_bin_nxt  = CNT_MAX;
            w_wrap_nxt = 1'b1;
          end
        end else begin
          w_bin_nxt = r_bin - WIDTH'(1);
        end
      end
    end
    w_at_end_nxt = up ? (w_bin_nxt == CNT_MAX) : (w_bin_nxt == CNT_ZERO);
  end

  bin2gray_comb #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .i_bin    (w_bin_nxt),
    .o_gray_c (w_gray_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin    <= '0;
      r_gray   <= '0;
      r_wrap   <= 1'b0;
      r_at_end <= 1'b0;
    end else begin
      r_bin    <= w_bin_nxt;
      r_gray   <= w_gray_nxt;
      r_wrap   <= w_wrap_nxt;
      r_at_end <= w_at_end_nxt;
    end
  end

  assign gray   = r_gray;
  assign wrap   = r_wrap;
  assign at_end = r_at_end;
`ifdef GRAY_CNT_BIN_OUT_EN
  assign bin    = r_bin;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: directed vector table, saturate-mode sequence and
// randomized run against a reference model, on a wrapping and a saturating DUT.
module tb_gray_counter;
  import gray_pkg::*;

  localparam int unsigned W   = 4;
  localparam int          LIM = 16;

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lv;
    logic [3:0] eg;
    logic       ew;
    logic       ea;
  } vec_t;

  logic       clk;
  logic       rst, en, up, load;
  logic [3:0] lv;
  logic [3:0] gray_w, gray_s;
  logic       wrap_w, wrap_s, at_end_w, at_end_s;
`ifdef GRAY_CNT_BIN_OUT_EN
  logic [3:0] bin_w, bin_s;
`endif

  int   n_chk;
  int   n_fail;
  vec_t vq[$];
  int   g_tab[LIM];
  logic [3:0] up_seq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  gray_counter #(.WIDTH(W), .WRAP(1'b1)) u_dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .gray(gray_w), .wrap(wrap_w), .at_end(at_end_w)
`ifdef GRAY_CNT_BIN_OUT_EN
    , .bin(bin_w)
`endif
  );

  gray_counter #(.WIDTH(W), .WRAP(1'b0)) u_dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .gray(gray_s), .wrap(wrap_s), .at_end(at_end_s)
`ifdef GRAY_CNT_BIN_OUT_EN
    , .bin(bin_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic l, input logic e, input logic u,
                              input logic [3:0] v, input logic [3:0] eg,
                              input logic ew, input logic ea);
    vec_t x;
    x.rst = r; x.load = l; x.en = e; x.up = u; x.lv = v;
    x.eg = eg; x.ew = ew; x.ea = ea;
    vq.push_back(x);
  endfunction

  // Drive inputs just after an edge, then sample 1 time unit past the next edge.
  task automatic drive(input logic r, input logic l, input logic e, input logic u,
                       input logic [3:0] v);
    rst = r; load = l; en = e; up = u; lv = v;
    @(posedge clk);
    #1;
  endtask

  // Reference: integer count moved by +/-1; stepping outside [0,LIM) is a range end.
  task automatic model_step(input bit wmode, input logic r, input logic l, input logic e,
                            input logic u, input int v, inout int cnt,
                            output int w, output int a);
    int nxt;
    w = 0;
    if (r) cnt = 0;
    else if (l) cnt = v;
    else if (e) begin
      nxt = u ? cnt + 1 : cnt - 1;
      if (nxt < 0 || nxt >= LIM) begin
        if (wmode) begin
          cnt = (nxt + LIM) % LIM;
          w   = 1;
        end
      end else begin
        cnt = nxt;
      end
    end
    a = r ? 0 : (u ? int'(cnt == LIM - 1) : int'(cnt == 0));
  endtask

  initial begin
    int size;
    int cw, cs, ew, es, aw, as_;
    logic [3:0] prev_g;
    logic r, l, e, u;
    logic [3:0] v;

    n_chk = 0;
    n_fail = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = '0;

    // Gray sequence built by reflect-and-prefix.
    g_tab[0] = 0;
    size = 1;
    for (int b = 0; b < int'(W); b++) begin
      for (int i = 0; i < size; i++) g_tab[size + i] = g_tab[size - 1 - i] + (1 << b);
      size = size * 2;
    end

    // Directed vectors for the wrapping DUT.
    add(1, 0, 0, 1, 4'h0, 4'h0, 0, 0);
    add(1, 0, 0, 1, 4'h0, 4'h0, 0, 0);
    add(0, 0, 0, 1, 4'h0, 4'h0, 0, 0);
    add(0, 0, 0, 1, 4'h0, 4'h0, 0, 0);
    for (int k = 0; k < 16; k++) add(0, 0, 1, 1, 4'h0, up_seq[k], k == 15, k == 14);
    add(0, 1, 0, 0, 4'h5, 4'h7, 0, 0);
    add(0, 0, 1, 0, 4'h0, 4'h6, 0, 0);
    add(0, 0, 1, 0, 4'h0, 4'h2, 0, 0);
    add(0, 0, 1, 0, 4'h0, 4'h3, 0, 0);
    add(0, 0, 1, 0, 4'h0, 4'h1, 0, 0);
    add(0, 0, 1, 0, 4'h0, 4'h0, 0, 1);
    add(0, 0, 1, 0, 4'h0, 4'h8, 1, 0);
    add(0, 1, 1, 1, 4'h3, 4'h2, 0, 0);
    add(1, 1, 1, 1, 4'h9, 4'h0, 0, 0);
    add(0, 0, 0, 0, 4'h0, 4'h0, 0, 1);
    add(0, 0, 0, 1, 4'h0, 4'h0, 0, 0);

    prev_g = '0;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].load, vq[i].en, vq[i].up, vq[i].lv);
      chk($sformatf("vec%0d gray", i), 32'(gray_w), 32'(vq[i].eg));
      chk($sformatf("vec%0d wrap", i), 32'(wrap_w), 32'(vq[i].ew));
      chk($sformatf("vec%0d at_end", i), 32'(at_end_w), 32'(vq[i].ea));
      if (vq[i].en && !vq[i].load && !vq[i].rst)
        chk($sformatf("vec%0d onebit", i), 32'($countones(gray_w ^ prev_g)), 32'd1);
      prev_g = gray_w;
    end

    // Saturating DUT at both range ends.
    drive(0, 1, 0, 1, 4'hE);
    chk("sat load14 gray", 32'(gray_s), 32'h9);
    chk("sat load14 at_end", 32'(at_end_s), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 1, 4'h0);
      chk($sformatf("sat up%0d gray", k), 32'(gray_s), 32'h8);
      chk($sformatf("sat up%0d at_end", k), 32'(at_end_s), 32'd1);
      chk($sformatf("sat up%0d wrap", k), 32'(wrap_s), 32'd0);
    end
    drive(0, 1, 0, 0, 4'h0);
    chk("sat load0 at_end", 32'(at_end_s), 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1, 0, 4'h0);
      chk($sformatf("sat dn%0d gray", k), 32'(gray_s), 32'h0);
      chk($sformatf("sat dn%0d wrap", k), 32'(wrap_s), 32'd0);
      chk($sformatf("sat dn%0d at_end", k), 32'(at_end_s), 32'd1);
    end
    drive(0, 0, 1, 1, 4'h0);
    chk("sat reverse gray", 32'(gray_s), 32'h1);
    chk("sat reverse at_end", 32'(at_end_s), 32'd0);

    // Randomized run against the reference model, both DUTs.
    cw = 0; cs = 0;
    for (int c = 0; c < 200; c++) begin
      r = (c == 0) || ($urandom_range(31) == 0);
      l = ($urandom_range(7) == 0);
      e = ($urandom_range(3) != 0);
      u = 1'($urandom_range(1));
      v = 4'($urandom_range(15));
      model_step(1'b1, r, l, e, u, int'(v), cw, ew, aw);
      model_step(1'b0, r, l, e, u, int'(v), cs, es, as_);
      drive(r, l, e, u, v);
      chk($sformatf("rnd%0d w gray", c), 32'(gray_w), 32'(g_tab[cw]));
      chk($sformatf("rnd%0d w wrap", c), 32'(wrap_w), 32'(ew));
      chk($sformatf("rnd%0d w at_end", c), 32'(at_end_w), 32'(aw));
      chk($sformatf("rnd%0d w g2b", c), gray2bin(32'(gray_w)), 32'(cw));
      chk($sformatf("rnd%0d s gray", c), 32'(gray_s), 32'(g_tab[cs]));
      chk($sformatf("rnd%0d s wrap", c), 32'(wrap_s), 32'(es));
      chk($sformatf("rnd%0d s at_end", c), 32'(at_end_s), 32'(as_));
`ifdef GRAY_CNT_BIN_OUT_EN
      chk($sformatf("rnd%0d w bin", c), 32'(bin_w), 32'(cw));
      chk($sformatf("rnd%0d s bin", c), 32'(bin_s), 32'(cs));
      chk($sformatf("rnd%0d w g2b_bin", c), gray2bin(32'(gray_w)), 32'(bin_w));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
